// File: rtl/preamble_peak_detector.sv
// Preamble peak detector: qualifies correlator threshold crossings with a plateau, searches a
// bounded window for the metric peak, and reports it on a side event stream.
module preamble_peak_detector #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned WINDOW_LEN = 64,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned IDX_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [15:0]            cfg_threshold,
    input  logic [CNT_W-1:0]       cfg_plateau,
    input  logic [CNT_W-1:0]       cfg_search,
    input  logic [CNT_W-1:0]       cfg_holdoff,
    input  logic [WIDTH+47:0]      i_tdata,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [WIDTH-1:0]       o_tdata,
    output logic                   o_tuser,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [IDX_W+31:0]      o_event_tdata,
    output logic                   o_event_tvalid,
    input  logic                   o_event_tready,
    output logic                   event_overflow
);

    localparam int unsigned      PhaseShift = $clog2(WINDOW_LEN);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    typedef enum logic [1:0] {StIdle, StPlateau, StSearch, StHoldoff} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   plat_cnt_q, plat_cnt_d;
    logic [CNT_W-1:0]   srch_cnt_q, srch_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic signed [17:0] peak_metric_q, peak_metric_d;
    logic [15:0]        peak_phase_q, peak_phase_d;
    logic [IDX_W-1:0]   peak_idx_q, peak_idx_d;

    logic [WIDTH-1:0]   o_tdata_q, o_tdata_d;
    logic               o_tuser_q, o_tuser_d;
    logic               o_tvalid_q, o_tvalid_d;
    logic [IDX_W+31:0]  ev_data_q, ev_data_d;
    logic               ev_valid_q, ev_valid_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   in_sample;
    logic [15:0]        in_power;
    logic [15:0]        in_mag;
    logic signed [15:0] in_phase;
    logic [31:0]        power_prod;
    logic [15:0]        scaled_power;
    logic signed [17:0] metric;
    logic               above;
    logic [15:0]        phase_scaled;
    logic               beat;
    logic               peak_win;
    logic               fire;
    logic               tuser_beat;
    logic [15:0]        peak_metric_sat;

    logic [CNT_W-1:0]   plat_eff, srch_eff;
    logic [CNT_W-1:0]   plat_inc, srch_inc, hold_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    assign in_sample = i_tdata[WIDTH-1:0];
    assign in_power  = i_tdata[WIDTH+15:WIDTH];
    assign in_mag    = i_tdata[WIDTH+31:WIDTH+16];
    assign in_phase  = $signed(i_tdata[WIDTH+47:WIDTH+32]);

    // Q0.16 threshold: keep the integer part of power*threshold
    assign power_prod   = 32'(in_power) * 32'(cfg_threshold);
    assign scaled_power = power_prod[31:16];
    assign metric       = $signed({2'b00, in_mag}) - $signed({2'b00, scaled_power});
    assign above        = metric > 18'sd0;
    assign phase_scaled = 16'(in_phase >>> PhaseShift);

    assign i_tready = o_tready || !o_tvalid_q;
    assign beat     = i_tvalid && i_tready;
    assign peak_win = metric > peak_metric_q;

    assign plat_eff = (cfg_plateau == '0) ? CntOne : cfg_plateau;
    assign srch_eff = (cfg_search == '0) ? CntOne : cfg_search;
    assign plat_inc = sat_inc(plat_cnt_q);
    assign srch_inc = sat_inc(srch_cnt_q);
    assign hold_inc = sat_inc(hold_cnt_q);

    always_comb begin
        state_d       = state_q;
        plat_cnt_d    = plat_cnt_q;
        srch_cnt_d    = srch_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        peak_metric_d = peak_metric_q;
        peak_phase_d  = peak_phase_q;
        peak_idx_d    = peak_idx_q;
        fire          = 1'b0;
        tuser_beat    = 1'b0;
        if (beat) begin
            unique case (state_q)
                StIdle: begin
                    if (above) begin
                        tuser_beat    = 1'b1;
                        peak_metric_d = metric;
                        peak_phase_d  = phase_scaled;
                        peak_idx_d    = idx_q;
                        plat_cnt_d    = CntOne;
                        // A plateau of one is already satisfied by the crossing beat
                        if (CntOne >= plat_eff) begin
                            state_d    = StSearch;
                            srch_cnt_d = '0;
                        end else begin
                            state_d = StPlateau;
                        end
                    end
                end
                StPlateau: begin
                    if (!above) begin
                        state_d    = StIdle;
                        plat_cnt_d = '0;
                    end else begin
                        plat_cnt_d = plat_inc;
                        if (peak_win) begin
                            peak_metric_d = metric;
                            peak_phase_d  = phase_scaled;
                            peak_idx_d    = idx_q;
                        end
                        if (plat_inc >= plat_eff) begin
                            state_d    = StSearch;
                            srch_cnt_d = '0;
                        end
                    end
                end
                StSearch: begin
                    if (peak_win) begin
                        peak_metric_d = metric;
                        peak_phase_d  = phase_scaled;
                        peak_idx_d    = idx_q;
                    end
                    srch_cnt_d = srch_inc;
                    if (srch_inc >= srch_eff) begin
                        fire       = 1'b1;
                        state_d    = StHoldoff;
                        hold_cnt_d = '0;
                    end
                end
                StHoldoff: begin
                    hold_cnt_d = hold_inc;
                    if (hold_inc >= cfg_holdoff) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        peak_metric_sat = peak_metric_d[15:0];
        if (peak_metric_d[17]) begin
            peak_metric_sat = '0;
        end else if (peak_metric_d[16]) begin
            peak_metric_sat = 16'hFFFF;
        end
    end

    always_comb begin
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tuser_d  = o_tuser_q;
        idx_d      = idx_q;
        if (beat) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = in_sample;
            o_tuser_d  = tuser_beat;
            idx_d      = idx_q + 1'b1;
        end else if (o_tready) begin
            o_tvalid_d = 1'b0;
            o_tuser_d  = 1'b0;
        end
    end

    // An event slot freed by the consumer this cycle may be refilled at once
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_data_d  = ev_data_q;
        overflow_d = overflow_q;
        if (ev_valid_q && o_event_tready) begin
            ev_valid_d = 1'b0;
        end
        if (fire) begin
            if (!ev_valid_q || o_event_tready) begin
                ev_valid_d = 1'b1;
                ev_data_d  = {peak_idx_d, peak_phase_d, peak_metric_sat};
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q       <= StIdle;
            plat_cnt_q    <= '0;
            srch_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            idx_q         <= '0;
            peak_metric_q <= '0;
            peak_phase_q  <= '0;
            peak_idx_q    <= '0;
            o_tdata_q     <= '0;
            o_tuser_q     <= 1'b0;
            o_tvalid_q    <= 1'b0;
            ev_data_q     <= '0;
            ev_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            plat_cnt_q    <= plat_cnt_d;
            srch_cnt_q    <= srch_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            idx_q         <= idx_d;
            peak_metric_q <= peak_metric_d;
            peak_phase_q  <= peak_phase_d;
            peak_idx_q    <= peak_idx_d;
            o_tdata_q     <= o_tdata_d;
            o_tuser_q     <= o_tuser_d;
            o_tvalid_q    <= o_tvalid_d;
            ev_data_q     <= ev_data_d;
            ev_valid_q    <= ev_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign o_tdata        = o_tdata_q;
    assign o_tuser        = o_tuser_q;
    assign o_tvalid       = o_tvalid_q;
    assign o_event_tdata  = ev_data_q;
    assign o_event_tvalid = ev_valid_q;
    assign event_overflow = overflow_q;

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Bench for preamble_peak_detector: directed scenarios plus a long randomized stream checked
// against a position-based reference model of the detection rules.
module tb_preamble_peak_detector;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned WINDOW_LEN = 64;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned IDX_W      = 32;
    localparam int unsigned DW         = WIDTH + 48;
    localparam int          Win        = 64;

    logic                 clk = 1'b0;
    logic                 reset, clear;
    logic [15:0]          cfg_threshold;
    logic [CNT_W-1:0]     cfg_plateau, cfg_search, cfg_holdoff;
    logic [DW-1:0]        i_tdata;
    logic                 i_tvalid, i_tready;
    logic [WIDTH-1:0]     o_tdata;
    logic                 o_tuser, o_tvalid, o_tready;
    logic [IDX_W+31:0]    o_event_tdata;
    logic                 o_event_tvalid, o_event_tready, event_overflow;

    int checks = 0;
    int errors = 0;
    int last_cycles = 0;

    logic [DW-1:0]        stim_q[$];
    logic [WIDTH-1:0]     out_data_q[$];
    bit                   out_user_q[$];
    logic [IDX_W+31:0]    ev_q[$];
    bit                   exp_user[];
    logic [IDX_W+31:0]    exp_ev_q[$];

    preamble_peak_detector #(
        .WIDTH(WIDTH), .WINDOW_LEN(WINDOW_LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .cfg_threshold(cfg_threshold), .cfg_plateau(cfg_plateau),
        .cfg_search(cfg_search), .cfg_holdoff(cfg_holdoff),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_event_tdata(o_event_tdata), .o_event_tvalid(o_event_tvalid),
        .o_event_tready(o_event_tready), .event_overflow(event_overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so handshakes are stable at negedge
    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            out_data_q.push_back(o_tdata);
            out_user_q.push_back(o_tuser);
        end
        if (o_event_tvalid && o_event_tready) ev_q.push_back(o_event_tdata);
    end

    function automatic int beat_metric(input logic [DW-1:0] b, input int unsigned thr);
        longint pw, mag;
        pw  = longint'(b[WIDTH+15:WIDTH]);
        mag = longint'(b[WIDTH+31:WIDTH+16]);
        return int'(mag - (pw * longint'(thr)) / 65536);
    endfunction

    function automatic logic [15:0] beat_phase(input logic [DW-1:0] b);
        logic signed [15:0] raw;
        int p, q;
        raw = b[WIDTH+47:WIDTH+32];
        p = int'(raw);
        q = p / Win;
        if (p < 0 && (p % Win) != 0) q = q - 1;
        return q[15:0];
    endfunction

    function automatic logic [15:0] sat16(input int m);
        if (m < 0) return 16'd0;
        if (m > 65535) return 16'hFFFF;
        return m[15:0];
    endfunction

    // Walks the accepted beats: crossing, plateau run, search window, argmax, hold-off
    function automatic void build_model(input int unsigned thr, input int plat, input int srch,
                                        input int hold);
        int n, p_eff, s_eff, h_eff, i, fail, e, best;
        int m[];
        logic [15:0] ph[];
        n = stim_q.size();
        p_eff = (plat == 0) ? 1 : plat;
        s_eff = (srch == 0) ? 1 : srch;
        h_eff = (hold == 0) ? 1 : hold;
        m = new[n];
        ph = new[n];
        exp_user = new[n];
        exp_ev_q.delete();
        for (int k = 0; k < n; k++) begin
            m[k] = beat_metric(stim_q[k], thr);
            ph[k] = beat_phase(stim_q[k]);
            exp_user[k] = 1'b0;
        end
        i = 0;
        while (i < n) begin
            if (m[i] <= 0) begin
                i++;
                continue;
            end
            exp_user[i] = 1'b1;
            fail = -1;
            for (int k = i + 1; k < i + p_eff && k < n; k++) begin
                if (m[k] <= 0) begin
                    fail = k;
                    break;
                end
            end
            if (fail >= 0) begin
                i = fail + 1;
                continue;
            end
            e = i + p_eff + s_eff - 1;
            if (e >= n) break;
            best = i;
            for (int k = i + 1; k <= e; k++) if (m[k] > m[best]) best = k;
            exp_ev_q.push_back({32'(best), ph[best], sat16(m[best])});
            i = e + h_eff + 1;
        end
    endfunction

    task automatic push_run(input int count, input int mag);
        logic [DW-1:0] b;
        int idx;
        for (int k = 0; k < count; k++) begin
            idx = stim_q.size();
            b = {16'(idx * 64), 16'(mag), 16'd1000, WIDTH'($urandom)};
            stim_q.push_back(b);
        end
    endtask

    task automatic set_mag(input int idx, input int mag);
        logic [DW-1:0] b;
        b = stim_q[idx];
        b[WIDTH+31:WIDTH+16] = 16'(mag);
        stim_q[idx] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_test();
        cfg_threshold = 16'hCCCC;
        cfg_plateau = 16'd4;
        cfg_search = 16'd8;
        cfg_holdoff = 16'd16;
        o_event_tready = 1'b1;
        do_reset();
        stim_q.delete();
        out_data_q.delete();
        out_user_q.delete();
        ev_q.delete();
    endtask

    task automatic drive_stream(input int vpct, input int rpct, input int bound);
        int k, cyc;
        k = 0;
        cyc = 0;
        while (k < stim_q.size() && cyc < bound) begin
            @(posedge clk); #1;
            i_tvalid = ($urandom_range(99) < vpct);
            i_tdata = stim_q[k];
            o_tready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (i_tvalid && i_tready) k++;
            cyc++;
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        last_cycles = cyc;
        checks++;
        if (k != stim_q.size()) begin
            errors++;
            $display("FAIL stream_bound: accepted %0d beats, required %0d", k, stim_q.size());
        end
    endtask

    task automatic drain();
        o_tready = 1'b1;
        i_tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks += 7;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", o_tvalid); end
        if (o_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b want 0", o_tuser); end
        if (o_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", o_tdata); end
        if (o_event_tvalid !== 1'b0) begin errors++; $display("FAIL rst_evvalid: got %b want 0", o_event_tvalid); end
        if (o_event_tdata !== '0) begin errors++; $display("FAIL rst_evdata: got %h want 0", o_event_tdata); end
        if (event_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", event_overflow); end
        if (i_tready !== 1'b1) begin errors++; $display("FAIL rst_itready: got %b want 1", i_tready); end
    endtask

    task automatic test_detection();
        logic [63:0] exp_ev;
        int nu, first;
        start_test();
        push_run(10, 0);
        push_run(20, 900);
        set_mag(15, 980);
        drive_stream(100, 100, 200);
        drain();
        nu = 0; first = -1;
        foreach (out_user_q[k]) if (out_user_q[k]) begin nu++; if (first < 0) first = k; end
        exp_ev = {32'd15, 16'd15, 16'd181};
        checks += 4;
        if (out_data_q.size() != 30) begin errors++; $display("FAIL det_count: got %0d want 30", out_data_q.size()); end
        if (nu != 1 || first != 10) begin errors++; $display("FAIL det_tuser: got n=%0d at %0d want 1 at 10", nu, first); end
        if (ev_q.size() != 1) begin errors++; $display("FAIL det_evcount: got %0d want 1", ev_q.size()); end
        else if (ev_q[0] !== exp_ev) begin errors++; $display("FAIL det_event: got %h want %h", ev_q[0], exp_ev); end
    endtask

    task automatic test_short_plateau();
        logic [63:0] exp_ev;
        int nu_early, nu;
        start_test();
        push_run(10, 0);
        push_run(3, 900);
        push_run(7, 0);
        push_run(15, 900);
        drive_stream(100, 100, 200);
        drain();
        nu_early = 0; nu = 0;
        foreach (out_user_q[k]) if (out_user_q[k]) begin nu++; if (k < 20) nu_early++; end
        exp_ev = {32'd20, 16'd20, 16'd101};
        checks += 4;
        if (nu_early != 1 || out_user_q[10] !== 1'b1) begin errors++; $display("FAIL short_tuser: got %0d early marks want 1 at 10", nu_early); end
        if (nu != 2 || out_user_q[20] !== 1'b1) begin errors++; $display("FAIL short_rearm: got %0d marks want 2 (10, 20)", nu); end
        if (ev_q.size() != 1) begin errors++; $display("FAIL short_evcount: got %0d want 1", ev_q.size()); end
        else if (ev_q[0] !== exp_ev) begin errors++; $display("FAIL short_event: got %h want %h", ev_q[0], exp_ev); end
    endtask

    task automatic test_tie();
        logic [63:0] exp_ev;
        start_test();
        push_run(10, 0);
        push_run(20, 900);
        set_mag(12, 950);
        set_mag(14, 950);
        drive_stream(100, 100, 200);
        drain();
        exp_ev = {32'd12, 16'd12, 16'd151};
        checks += 1;
        if (ev_q.size() != 1) begin errors++; $display("FAIL tie_evcount: got %0d want 1", ev_q.size()); end
        else begin
            checks += 1;
            if (ev_q[0] !== exp_ev) begin errors++; $display("FAIL tie_event: got %h want %h", ev_q[0], exp_ev); end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_ev;
        start_test();
        o_event_tready = 1'b0;
        push_run(10, 0);
        push_run(20, 900);
        set_mag(13, 960);
        push_run(15, 0);
        push_run(25, 900);
        drive_stream(100, 100, 400);
        drain();
        exp_ev = {32'd13, 16'd13, 16'd161};
        checks += 5;
        if (last_cycles != 70) begin errors++; $display("FAIL ovf_rate: got %0d cycles want 70", last_cycles); end
        if (out_data_q.size() != 70) begin errors++; $display("FAIL ovf_samples: got %0d want 70", out_data_q.size()); end
        if (o_event_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b want 1", o_event_tvalid); end
        if (o_event_tdata !== exp_ev) begin errors++; $display("FAIL ovf_data: got %h want %h", o_event_tdata, exp_ev); end
        if (event_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", event_overflow); end
        o_event_tready = 1'b1;
        @(posedge clk); #1;
        checks += 3;
        if (o_event_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_release: got %b want 0", o_event_tvalid); end
        if (event_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", event_overflow); end
        if (ev_q.size() != 1) begin errors++; $display("FAIL ovf_evcount: got %0d want 1", ev_q.size()); end
    endtask

    task automatic test_reset_mid_search(input bit use_clear);
        logic [63:0] exp_ev;
        logic [DW-1:0] first_beat;
        int nu, first;
        string nm;
        nm = use_clear ? "clear" : "reset";
        start_test();
        push_run(10, 0);
        push_run(11, 900);
        drive_stream(100, 100, 200);
        if (use_clear) clear = 1'b1;
        else reset = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks += 6;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL %s_tvalid: got %b want 0", nm, o_tvalid); end
        if (o_tuser !== 1'b0) begin errors++; $display("FAIL %s_tuser: got %b want 0", nm, o_tuser); end
        if (o_tdata !== '0) begin errors++; $display("FAIL %s_tdata: got %h want 0", nm, o_tdata); end
        if (o_event_tvalid !== 1'b0) begin errors++; $display("FAIL %s_evvalid: got %b want 0", nm, o_event_tvalid); end
        if (o_event_tdata !== '0) begin errors++; $display("FAIL %s_evdata: got %h want 0", nm, o_event_tdata); end
        if (event_overflow !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %b want 0", nm, event_overflow); end
        stim_q.delete();
        out_data_q.delete();
        out_user_q.delete();
        ev_q.delete();
        push_run(3, 0);
        push_run(18, 900);
        first_beat = stim_q[0];
        drive_stream(100, 100, 200);
        drain();
        nu = 0; first = -1;
        foreach (out_user_q[k]) if (out_user_q[k]) begin nu++; if (first < 0) first = k; end
        exp_ev = {32'd3, 16'd3, 16'd101};
        checks += 3;
        if (out_data_q.size() == 0 || out_data_q[0] !== first_beat[WIDTH-1:0]) begin
            errors++;
            $display("FAIL %s_first: got %0d beats, want first sample %h", nm, out_data_q.size(), first_beat[WIDTH-1:0]);
        end
        if (nu != 1 || first != 3) begin errors++; $display("FAIL %s_tuser: got n=%0d at %0d want 1 at 3", nm, nu, first); end
        if (ev_q.size() != 1) begin errors++; $display("FAIL %s_evcount: got %0d want 1", nm, ev_q.size()); end
        else begin
            checks += 1;
            if (ev_q[0] !== exp_ev) begin errors++; $display("FAIL %s_event: got %h want %h", nm, ev_q[0], exp_ev); end
        end
    endtask

    task automatic test_random();
        int n_beats, pw, mag, ne;
        bit burst;
        logic [31:0] ph, smp;
        start_test();
        cfg_threshold = 16'($urandom_range(32768, 65535));
        cfg_plateau = 16'($urandom_range(0, 4));
        cfg_search = 16'($urandom_range(0, 12));
        cfg_holdoff = 16'($urandom_range(0, 20));
        n_beats = 10000;
        burst = 1'b0;
        for (int k = 0; k < n_beats; k++) begin
            if ($urandom_range(99) < 8) burst = !burst;
            pw = int'($urandom_range(400, 1200));
            mag = burst ? int'($urandom_range(700, 1400)) : int'($urandom_range(0, 600));
            ph = $urandom;
            smp = $urandom;
            stim_q.push_back({ph[15:0], 16'(mag), 16'(pw), smp});
        end
        build_model(cfg_threshold, cfg_plateau, cfg_search, cfg_holdoff);
        drive_stream(50, 50, 70000);
        drain();
        checks += 1;
        if (out_data_q.size() != n_beats) begin
            errors++;
            $display("FAIL rnd_count: got %0d samples want %0d", out_data_q.size(), n_beats);
        end
        for (int k = 0; k < out_data_q.size() && k < n_beats; k++) begin
            logic [DW-1:0] b;
            b = stim_q[k];
            checks += 2;
            if (out_data_q[k] !== b[WIDTH-1:0]) begin
                errors++;
                $display("FAIL rnd_data[%0d]: got %h want %h", k, out_data_q[k], b[WIDTH-1:0]);
            end
            if (out_user_q[k] !== exp_user[k]) begin
                errors++;
                $display("FAIL rnd_tuser[%0d]: got %b want %b", k, out_user_q[k], exp_user[k]);
            end
        end
        checks += 1;
        if (ev_q.size() != exp_ev_q.size() || exp_ev_q.size() == 0) begin
            errors++;
            $display("FAIL rnd_evcount: got %0d events want %0d (nonzero)", ev_q.size(), exp_ev_q.size());
        end
        ne = (ev_q.size() < exp_ev_q.size()) ? ev_q.size() : exp_ev_q.size();
        for (int k = 0; k < ne; k++) begin
            checks += 1;
            if (ev_q[k] !== exp_ev_q[k]) begin
                errors++;
                $display("FAIL rnd_event[%0d]: got %h want %h", k, ev_q[k], exp_ev_q[k]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        i_tvalid = 1'b0;
        i_tdata = '0;
        o_tready = 1'b1;
        o_event_tready = 1'b1;
        cfg_threshold = 16'hCCCC;
        cfg_plateau = 16'd4;
        cfg_search = 16'd8;
        cfg_holdoff = 16'd16;
        test_reset();
        test_detection();
        test_short_plateau();
        test_tie();
        test_overflow();
        test_reset_mid_search(1'b0);
        test_reset_mid_search(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
